apb_master_param: RTL

Parametrised APB3/APB4 requester for the UART/GPIO peripheral subsystem.
- Accepts single read/write commands on a valid/ready command port.
- Decodes the upper address bits into one of NUM_SLAVES PSEL lines.
- Drives the IDLE/SETUP/ACCESS protocol.
- Returns read data and error status on a one-cycle response strobe.
- Adds wait-state timeout, PSLVERR capture and decode-error handling.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_addr_decode.sv | 25 ++
 rtl/apb_master_param.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types, default widths and a constant-evaluable clog2 for the APB requester.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_e;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_NUM_SLAVES = 2;
  localparam int unsigned DEF_TIMEOUT    = 255;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = unsigned'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Slave index to one-hot PSEL pattern; flags indices with no attached slave.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned SEL_BITS   = 1
) (
  input  logic [SEL_BITS-1:0]   idx,
  output logic [NUM_SLAVES-1:0] sel_onehot,
  output logic                  dec_err
);

  // Match the index against every populated slot; no match means decode error.
  always_comb begin
    sel_onehot = '0;
    dec_err    = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SEL_BITS'(i)) begin
        sel_onehot[i] = 1'b1;
        dec_err       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_master_param.sv
// APB3/APB4 requester: single commands in, IDLE/SETUP/ACCESS on the bus,
// one-cycle response strobe out, with wait-state timeout and decode errors.
module apb_master_param
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned SEL_BITS = (clog2(NUM_SLAVES) > 1) ? clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W    = (clog2(TIMEOUT + 1) > 1) ? clog2(TIMEOUT + 1) : 1;

  state_e                state_q,     state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [NUM_SLAVES-1:0] psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic [ADDR_W-1:0]     paddr_q,     paddr_d;
  logic                  pwrite_q,    pwrite_d;
  logic [DATA_W-1:0]     pwdata_q,    pwdata_d;
  logic [STRB_W-1:0]     pstrb_q,     pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]      wait_cnt_q,  wait_cnt_d;

  logic [NUM_SLAVES-1:0] sel_onehot;
  logic                  dec_err;

  apb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS)
  ) u_decode (
    .idx        (cmd_addr[ADDR_W-1 -: SEL_BITS]),
    .sel_onehot (sel_onehot),
    .dec_err    (dec_err)
  );

  // Next-state and next-output logic; everything holds unless a transition says otherwise.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (dec_err) begin
            // Unpopulated slot: answer straight away without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = SETUP;
            psel_d    = sel_onehot;
            penable_d = 1'b0;
            paddr_d   = cmd_addr;
            pwrite_d  = cmd_write;
            pwdata_d  = cmd_wdata;
            pstrb_d   = cmd_write ? cmd_strb : '0;
          end
        end
      end

      SETUP: begin
        state_d    = ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end

      ACCESS: begin
        // PREADY is checked first so a ready slave wins over a same-cycle timeout.
        if (PREADY) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
          wait_cnt_d  = '0;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        psel_d      = '0;
        penable_d   = 1'b0;
        cmd_ready_d = 1'b1;
        wait_cnt_d  = '0;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
